// File: rtl/mulctl_pkg.sv
// Shared definitions for the bit-serial multiplier scheduler: operand/result
// widths, job counter width and FSM state encoding.
package mulctl_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 8;
  localparam int CYC_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RECV = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/mulctl_arb.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the
// priority pointer, and the pointer moves to the loser on every take.
module mulctl_arb (
  input  logic req0_i,
  input  logic req1_i,
  input  logic take_i,
  input  logic pri_i,
  output logic win_o,
  output logic pri_d_o
);

  // Winner selection
  always_comb begin
    win_o = 1'b0;
    if (req0_i && req1_i) begin
      win_o = pri_i;
    end else if (req1_i) begin
      win_o = 1'b1;
    end else begin
      win_o = 1'b0;
    end
  end

  // Pointer update: after a grant the other requester gets priority
  always_comb begin
    pri_d_o = pri_i;
    if (take_i) begin
      pri_d_o = ~win_o;
    end else begin
      pri_d_o = pri_i;
    end
  end

endmodule

// File: rtl/mulctl_sched.sv
// Scheduler for the 4x4 bit-serial multiplier core: arbitrate, serialize
// operands, deserialize product. Optional result check: MULCTL_CHECK_EN.
module mulctl_sched
  import mulctl_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ0,
  input  logic            REQ1,
  input  logic [OP_W-1:0] A0,
  input  logic [OP_W-1:0] B0,
  input  logic [OP_W-1:0] A1,
  input  logic [OP_W-1:0] B1,
  output logic            GNT0,
  output logic            GNT1,
  output logic            DONE0,
  output logic            DONE1,
  output logic [RES_W-1:0] P,
  output logic            BUSY,
  output logic            MRST,
  output logic            SA,
  output logic            SB,
  input  logic            SO,
  output logic            ERR
);

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [OP_W-1:0]    opa_q, opa_d, opb_q, opb_d;
  logic [RES_W-1:0]   sh_q, sh_d, p_q, p_d;
  logic               idx_q, idx_d, pri_q, pri_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               busy_q, busy_d, mrst_q, mrst_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               take_s, win_s;
  logic [RES_W-1:0]   res_s;

  assign take_s = (state_q == ST_IDLE) && (REQ0 || REQ1);
  assign res_s  = {SO, sh_q[RES_W-1:1]};

  mulctl_arb u_arb (
    .req0_i  (REQ0),
    .req1_i  (REQ1),
    .take_i  (take_s),
    .pri_i   (pri_q),
    .win_o   (win_s),
    .pri_d_o (pri_d)
  );

`ifdef MULCTL_CHECK_EN
  logic [RES_W-1:0] exp_q, exp_d;
  logic             err_q, err_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sh_d    = sh_q;
    p_d     = p_q;
    idx_d   = idx_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    sa_d    = 1'b0;
    sb_d    = 1'b0;
`ifdef MULCTL_CHECK_EN
    exp_d   = exp_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          idx_d   = win_s;
          opa_d   = win_s ? A1 : A0;
          opb_d   = win_s ? B1 : B0;
          sh_d    = {RES_W{1'b0}};
          gnt0_d  = ~win_s;
          gnt1_d  = win_s;
          state_d = ST_CLR;
`ifdef MULCTL_CHECK_EN
          exp_d   = win_s ? ({4'd0, A1} * {4'd0, B1}) : ({4'd0, A0} * {4'd0, B0});
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        cyc_d   = {CYC_W{1'b0}};
        sa_d    = opa_q[0];
        sb_d    = opb_q[0];
        state_d = ST_SEND;
      end
      ST_SEND: begin
        cyc_d = cyc_q + 5'd1;
        if (cyc_q == 5'd3) begin
          state_d = (MUL_LAT == 4) ? ST_RECV : ST_WAIT;
        end else begin
          sa_d = opa_q[cyc_q[1:0] + 2'd1];
          sb_d = opb_q[cyc_q[1:0] + 2'd1];
        end
      end
      ST_WAIT: begin
        cyc_d = cyc_q + 5'd1;
        if (cyc_q == CYC_W'(MUL_LAT - 1)) begin
          state_d = ST_RECV;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RECV: begin
        cyc_d = cyc_q + 5'd1;
        sh_d  = res_s;
        if (cyc_q == CYC_W'(MUL_LAT + 7)) begin
          p_d     = res_s;
          done0_d = ~idx_q;
          done1_d = idx_q;
          state_d = ST_DONE;
`ifdef MULCTL_CHECK_EN
          if (res_s != exp_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    mrst_d = (state_d == ST_CLR);
  end

  // State and output registers; the core is held in reset while RST is high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cyc_q   <= {CYC_W{1'b0}};
      opa_q   <= {OP_W{1'b0}};
      opb_q   <= {OP_W{1'b0}};
      sh_q    <= {RES_W{1'b0}};
      p_q     <= {RES_W{1'b0}};
      idx_q   <= 1'b0;
      pri_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      mrst_q  <= 1'b1;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sh_q    <= sh_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      pri_q   <= pri_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      mrst_q  <= mrst_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

`ifdef MULCTL_CHECK_EN
  // Expected product and sticky mismatch flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q <= {RES_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign DONE0 = done0_q;
  assign DONE1 = done1_q;
  assign P     = p_q;
  assign BUSY  = busy_q;
  assign MRST  = mrst_q;
  assign SA    = sa_q;
  assign SB    = sb_q;

endmodule

// File: doc/mulctl_sched.md
# mulctl_sched

Scheduler for the 4x4 bit-serial multiplier datapath. Arbitrates between two parallel requesters and serializes the granted operands LSB-first onto the datapath's serial inputs. It then deserializes the 8-bit serial product and returns it with a one-cycle done strobe. It sits between the parallel-operand clients and the serial multiplier core, and owns that core's synchronous reset.

## Interface
Parameters:
- MUL_LAT, 5, cycles from first operand bit on SA/SB to product bit 0 on SO; legal range 4..15.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ0, REQ1  in  1  level request; requester holds it and its operands until its grant.
- A0, B0, A1, B1  in  4  unsigned operands of requester 0 / 1.
- GNT0, GNT1  out  1  one-cycle grant pulse; operands latched on this cycle's entry.
- DONE0, DONE1  out  1  one-cycle completion pulse to the granted requester.
- P  out  8  product; updated on entry to DONE, held until the next DONE.
- BUSY  out  1  high in every state except IDLE.
- MRST  out  1  synchronous reset to multiplier core.
- SA, SB  out  1  serial operand bits to core.
- SO  in  1  serial product bit from core.
- ERR  out  1  sticky result-mismatch flag (see Configuration).

## Operation
- States: IDLE, CLR, SEND, WAIT, RECV, DONE. One job counter `cyc` (5 bits) cleared on entry to SEND.
- IDLE: REQ0 or REQ1 high -> latch winner's operands, pulse GNTx, go to CLR. No request -> stay.
- Arbitration: a lone request always wins. Both high -> pointer PRI wins. After every grant PRI = the other index. PRI resets to 0.
- CLR: MRST=1 for exactly one cycle, then SEND.
- SEND: cyc 0..3. SA=opA[cyc], SB=opB[cyc]. Go to WAIT at cyc=3, or directly to RECV if MUL_LAT=4.
- WAIT: cyc 4..MUL_LAT-1. SA=SB=0.
- RECV: cyc MUL_LAT..MUL_LAT+7. Shift SO into result bit (cyc-MUL_LAT), LSB first. After 8 bits go to DONE.
- DONE: P = assembled result, DONEx=1 for the granted index, then IDLE.
- A REQ still high in IDLE after DONE is a new job; the requester drops REQ after GNT to avoid reissue.
- Requests arriving while BUSY are ignored until IDLE; REQ is level, so nothing is lost.
- Reset (any time, including mid-job): state=IDLE, PRI=0, GNTx=DONEx=0, P=0, SA=SB=0, BUSY=0, MRST=1, ERR=0. MRST falls on the first clock edge after RST release.
- Arithmetic: unsigned, 4x4 -> 8 bit, no truncation.

## Timing
- All outputs registered and reflect the current state.
- REQ sampled high in IDLE at cycle 0 -> GNT+MRST cycle 1, SA/SB bits cycles 2..5, SO sampled cycles 2+MUL_LAT..9+MUL_LAT, DONE+P cycle 10+MUL_LAT (15 at default).
- Job period, back-to-back: 11+MUL_LAT cycles, because IDLE takes one cycle between jobs.
- GNT and DONE never both high in the same cycle; GNT0 and GNT1 are never both high.

## Configuration
- MULCTL_CHECK_EN defined:
  - Latch the exact product opA*opB at grant.
  - On entry to DONE, compare it with the assembled result; on mismatch set ERR, which stays set until RST.
- Without MULCTL_CHECK_EN: no multiplier and no compare logic; ERR tied 0. The port list is identical in both builds.

## Structure
- Shared package/header mulctl_pkg: state encoding (IDLE..DONE), OP_W=4, RES_W=8, CYC_W=5.
- One sub-module, mulctl_arb: 2-way round-robin arbiter. Inputs: REQ0, REQ1, a take strobe and PRI. Outputs: winner index and PRI update.
- Everything else (FSM, serializer, deserializer, check) in mulctl_sched.

## Test plan
- REQ0, A0=3, B0=5, MUL_LAT=5, core model attached -> GNT0 at cycle 1, SA=1,1,0,0 over cycles 2..5, DONE0 at cycle 15, P=8'h0F.
- REQ0 and REQ1 together, A0=B0=15, A1=2, B1=7 -> requester 0 first with P=225 and DONE0; then GNT1, P=14, DONE1. A second simultaneous pair grants 0 first again, since PRI returned to 0 after serving requester 1.
- REQ1 alone with PRI=0 -> GNT1 at cycle 1, PRI becomes 0 after that grant.
- RST pulsed during RECV -> all outputs at reset values immediately; after release, REQ0 with A0=9, B0=9 -> P=81, no residue from the aborted job.
- MUL_LAT=4 -> no WAIT state, DONE at cycle 14; MUL_LAT=15 -> DONE at cycle 25, correct P for A=13, B=11 (143).
- With MULCTL_CHECK_EN, core model flips SO bit 3 for A=2, B=2 -> P=12, ERR=1 and stays 1 through later correct jobs until RST.
